alu_result_stage: RTL

- Registered result stage directly downstream of the 8-bit add/subtract unit.
- Captures sum, carry-out and overflow, and derives the N/Z/C/V status flags.
- Buffers results in a 2-entry skid FIFO behind a valid/ready handshake, so the ALU datapath can run while the consumer (register-file writeback / flag register) stalls.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_flag_gen.sv | 23 ++
 rtl/alu_result_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, flag bit positions and buffered entry type for the ALU result stage.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int FLAG_W    = 4;

  // Bit positions inside the {N,Z,C,V} flag nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [FLAG_W-1:0]    flags;
  } alu_result_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational N/Z/C/V derivation from the adder/subtractor outputs.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]  sum_i,
  input  logic              c_out_i,
  input  logic              overflow_i,
  input  logic              sub_i,
  output logic [FLAG_W-1:0] flags_o
);

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_N] = sum_i[WIDTH-1];
    flags_o[FLAG_Z] = (sum_i == '0);
    // a + ~b + 1 sets carry when no borrow occurred, so C is inverted for subtraction
    flags_o[FLAG_C] = c_out_i ^ sub_i;
    flags_o[FLAG_V] = overflow_i;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result/flag stage with a 2-entry skid FIFO.
// Optional sticky overflow flag when ALU_RESULT_STICKY_V_EN is defined.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_c_out,
  input  logic             in_overflow,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
`ifdef ALU_RESULT_STICKY_V_EN
  input  logic             sticky_clr,
  output logic             sticky_v,
`endif
  output logic [1:0]       occupancy
);

  if (DEPTH != 2) begin : g_depth_chk
    $error("alu_result_stage: DEPTH must be 2");
  end
  if (WIDTH != ALU_WIDTH) begin : g_width_chk
    $error("alu_result_stage: WIDTH must equal ALU_WIDTH");
  end

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              init_q;
  logic              push, pop;
  logic [FLAG_W-1:0] push_flags;
  alu_result_t       push_entry;
  alu_result_t       mem_q [2];
  alu_result_t       head;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .sum_i      (in_sum),
    .c_out_i    (in_c_out),
    .overflow_i (in_overflow),
    .sub_i      (in_sub),
    .flags_o    (push_flags)
  );

  always_comb begin
    push_entry        = '0;
    push_entry.result = in_sum;
    push_entry.flags  = push_flags;
  end

  // in_ready comes only from registered state, never from out_ready
  assign in_ready  = init_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      init_q   <= 1'b1;
    end
  end

  // Entries are cleared on reset so the head reads 0 instead of stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_result = head.result;
  assign out_flags  = head.flags;
  assign occupancy  = count_q;

`ifdef ALU_RESULT_STICKY_V_EN
  logic sticky_v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v_q <= 1'b0;
    end else if (push && push_flags[FLAG_V]) begin
      sticky_v_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_v_q <= 1'b0;
    end
  end

  assign sticky_v = sticky_v_q;
`endif

endmodule
